mem_writeburst_avalon: RTL and testbench
========================================

MEM_WRITEBURST_AVALON -- requirements
Module: mem_writeburst_avalon

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 The port list SHALL be:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- writeburst_do  in  1  level request; held until done
- writeburst_done  out  1  one-cycle pulse; last beat accepted
- writeburst_address  in  32  byte address of first byte
- writeburst_dword_length  in  2  2'd2 = two beats; any other value = one beat
- writeburst_byteenable_0  in  4  byte enables, beat 0
- writeburst_byteenable_1  in  4  byte enables, beat 1
- writeburst_data  in  56  packed little-endian bytes starting at address[1:0]
- avm_address  out  30  dword address (byte address [31:2])
- avm_writedata  out  32  beat data
- avm_byteenable  out  4  beat byte enables
- avm_burstcount  out  2  beats in burst (1 or 2)
- avm_write  out  1  write strobe
- avm_waitrequest  in  1  slave stall

Function
REQ-003 State machine states SHALL be IDLE, BEAT0, BEAT1, HOLDOFF.
REQ-004 In IDLE with writeburst_do=1, the block SHALL capture address, length, enables and aligned data, then enter BEAT0 on the next edge; it SHALL NOT sample request inputs again until IDLE.
REQ-005 Alignment SHALL be: 64-bit value = ({8'h00, data} << 8*address[1:0]); beat 0 data = [31:0]; beat 1 data = [63:32].
REQ-006 In BEAT0: avm_write=1, avm_address=captured address[31:2], avm_burstcount=beats, avm_byteenable=byteenable_0.
REQ-007 BEAT0 with avm_waitrequest=0 SHALL go to BEAT1 for two beats, else to HOLDOFF; with avm_waitrequest=1 it SHALL stay in BEAT0 with all avm_* outputs stable.
REQ-008 In BEAT1: avm_write=1, avm_address and avm_burstcount unchanged from BEAT0, avm_byteenable=byteenable_1; avm_waitrequest=0 SHALL go to HOLDOFF; avm_waitrequest=1 SHALL hold.
REQ-009 writeburst_done SHALL pulse high for exactly one cycle, the cycle after the last beat is accepted (first HOLDOFF cycle).
REQ-010 HOLDOFF SHALL last exactly one cycle, ignore writeburst_do and return to IDLE; it absorbs the upstream done-to-drop latency.
REQ-011 Minimum request-to-done latency SHALL be 2 cycles for one beat and 3 for two; back-to-back throughput SHALL be one burst per (beats+2) cycles.
REQ-012 Outside BEAT0/BEAT1, avm_write SHALL be 0 and avm_byteenable SHALL be 4'h0.
REQ-013 Requests arriving while not in IDLE SHALL NOT be lost; the level-held writeburst_do is re-sampled in IDLE.

Reset
REQ-014 Asserting rst at any time, including mid-burst, SHALL immediately force IDLE, writeburst_done=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, avm_burstcount=0, and clear all captured registers.
REQ-015 After rst deasserts, the first request SHALL be accepted no earlier than the following rising edge.

Configuration
REQ-016 Macro WRITEBURST_BEAT_TRIM_EN: when defined, a two-beat request with byteenable_1=4'h0 SHALL issue as a single beat at address[31:2]; a two-beat request with byteenable_0=4'h0 SHALL issue as a single beat at address[31:2]+1 using beat 1 data and enables.
REQ-017 When WRITEBURST_BEAT_TRIM_EN is undefined, the beat count SHALL follow writeburst_dword_length exactly, including all-zero enable beats.

Structure
REQ-018 State encodings (2-bit) and the burstcount width constant SHALL live in the shared defines file alongside `TRUE/`FALSE.
REQ-019 Data alignment (REQ-005) SHALL be a combinational sub-module, writeburst_align; it SHALL be the only sub-module.

Verification
REQ-020 Single beat: address=32'h1000, len=1, be0=4'hF, data=56'h00_0000_DDCC_BBAA -> one avm_write cycle: avm_address=30'h400, avm_writedata=32'hDDCCBBAA, burstcount=1; done pulses 2 cycles after do.
REQ-021 Unaligned two beats: address=32'h2003, len=2, be0=4'h8, be1=4'h7, data=56'h0000_00_44332211 -> beat 0 writedata[31:24]=8'h11; beat 1 writedata[23:0]=24'h443322; burstcount=2.
REQ-022 Stall: avm_waitrequest=1 for 3 cycles in BEAT0 and 2 cycles in BEAT1 -> avm_* stable throughout; exactly 2 accepted beats; one done pulse.
REQ-023 Holdoff: writeburst_do kept high 1 cycle after done -> no second burst starts; do kept high 2 cycles after done -> exactly one new burst.
REQ-024 Reset mid-burst: rst asserted during BEAT1 with waitrequest=1 -> avm_write=0 in the same cycle, no done pulse, IDLE after release.
REQ-025 With WRITEBURST_BEAT_TRIM_EN: len=2, be0=4'hF, be1=4'h0 -> burstcount=1, single beat; undefined -> burstcount=2, beat 1 byteenable=4'h0.

Source files
------------

// File: rtl/mem_writeburst_avalon_pkg.sv
// Shared definitions for the Avalon write-burst master: FSM state encodings,
// burstcount width and boolean helpers.
`ifndef MEM_WRITEBURST_AVALON_DEFINES
`define MEM_WRITEBURST_AVALON_DEFINES
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package mem_writeburst_avalon_pkg;

  localparam int unsigned BurstCountW = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBeat0   = 2'd1,
    StBeat1   = 2'd2,
    StHoldoff = 2'd3
  } state_e;

endpackage

// File: rtl/writeburst_align.sv
// Combinational byte-lane alignment: places the packed request bytes at the
// byte offset of the start address within a two-dword window.
module writeburst_align (
  input  logic [55:0] data,
  input  logic [1:0]  offset,
  output logic [63:0] aligned
);

  assign aligned = {8'h00, data} << {offset, 3'b000};

endmodule

// File: rtl/mem_writeburst_avalon.sv
// One- or two-beat Avalon-MM write burst master driven by a level-held request.
// Optional build macro WRITEBURST_BEAT_TRIM_EN drops an all-zero-enable beat.
module mem_writeburst_avalon
  import mem_writeburst_avalon_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   writeburst_do,
  output logic                   writeburst_done,
  input  logic [31:0]            writeburst_address,
  input  logic [1:0]             writeburst_dword_length,
  input  logic [3:0]             writeburst_byteenable_0,
  input  logic [3:0]             writeburst_byteenable_1,
  input  logic [55:0]            writeburst_data,
  output logic [29:0]            avm_address,
  output logic [31:0]            avm_writedata,
  output logic [3:0]             avm_byteenable,
  output logic [BurstCountW-1:0] avm_burstcount,
  output logic                   avm_write,
  input  logic                   avm_waitrequest
);

  state_e state_q, state_d;

  logic [29:0]            addr_q, cap_addr;
  logic [BurstCountW-1:0] burst_q, cap_burst;
  logic [7:0]             be_q, cap_be;
  logic [63:0]            data_q, cap_data;
  logic [63:0]            aligned;
  logic                   capture;

  writeburst_align u_align (
    .data    (writeburst_data),
    .offset  (writeburst_address[1:0]),
    .aligned (aligned)
  );

  // Values latched when a request is accepted; beat 0 lives in the low halves.
  always_comb begin
    cap_addr  = writeburst_address[31:2];
    cap_burst = (writeburst_dword_length == 2'd2) ? BurstCountW'(2) : BurstCountW'(1);
    cap_be    = {writeburst_byteenable_1, writeburst_byteenable_0};
    cap_data  = aligned;
`ifdef WRITEBURST_BEAT_TRIM_EN
    if (cap_burst == BurstCountW'(2)) begin
      if (writeburst_byteenable_1 == 4'h0) begin
        cap_burst = BurstCountW'(1);
      end else if (writeburst_byteenable_0 == 4'h0) begin
        // Only the second dword carries data: issue it alone as beat 0.
        cap_addr  = writeburst_address[31:2] + 30'd1;
        cap_burst = BurstCountW'(1);
        cap_be    = {4'h0, writeburst_byteenable_1};
        cap_data  = {32'h0, aligned[63:32]};
      end
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    capture         = `FALSE;
    avm_write       = `FALSE;
    avm_byteenable  = 4'h0;
    avm_writedata   = data_q[31:0];
    writeburst_done = `FALSE;
    unique case (state_q)
      StIdle: begin
        if (writeburst_do) begin
          capture = `TRUE;
          state_d = StBeat0;
        end
      end
      StBeat0: begin
        avm_write      = `TRUE;
        avm_byteenable = be_q[3:0];
        if (!avm_waitrequest) begin
          state_d = (burst_q == BurstCountW'(2)) ? StBeat1 : StHoldoff;
        end
      end
      StBeat1: begin
        avm_write      = `TRUE;
        avm_byteenable = be_q[7:4];
        avm_writedata  = data_q[63:32];
        if (!avm_waitrequest) begin
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        // Gives upstream one cycle to drop its request before IDLE samples it.
        writeburst_done = `TRUE;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      burst_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= cap_addr;
        burst_q <= cap_burst;
        be_q    <= cap_be;
        data_q  <= cap_data;
      end
    end
  end

  assign avm_address    = addr_q;
  assign avm_burstcount = burst_q;

endmodule

// File: tb/tb_mem_writeburst_avalon.sv
// Scoreboard bench for mem_writeburst_avalon: expected beats are queued at
// request time and popped as the Avalon slave accepts them.
module tb_mem_writeburst_avalon;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  bc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeburst_do;
  logic        writeburst_done;
  logic [31:0] writeburst_address;
  logic [1:0]  writeburst_dword_length;
  logic [3:0]  writeburst_byteenable_0;
  logic [3:0]  writeburst_byteenable_1;
  logic [55:0] writeburst_data;
  logic [29:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [1:0]  avm_burstcount;
  logic        avm_write;
  logic        avm_waitrequest;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    done_cnt = 0;
  int    exp_done = 0;

  mem_writeburst_avalon dut (
    .clk                     (clk),
    .rst                     (rst),
    .writeburst_do           (writeburst_do),
    .writeburst_done         (writeburst_done),
    .writeburst_address      (writeburst_address),
    .writeburst_dword_length (writeburst_dword_length),
    .writeburst_byteenable_0 (writeburst_byteenable_0),
    .writeburst_byteenable_1 (writeburst_byteenable_1),
    .writeburst_data         (writeburst_data),
    .avm_address             (avm_address),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_burstcount          (avm_burstcount),
    .avm_write               (avm_write),
    .avm_waitrequest         (avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Reference model: returns the number of beats the request should produce.
  function automatic int push_exp(input logic [31:0] a, input logic [1:0] len,
                                  input logic [3:0] b0, input logic [3:0] b1,
                                  input logic [55:0] d);
    logic [63:0] al;
    beat_t       bt;
    int          n;
    int          sh;
    sh = 8 * int'(a[1:0]);
    al = {8'h00, d} << sh;
    n  = (len == 2'd2) ? 2 : 1;
`ifdef WRITEBURST_BEAT_TRIM_EN
    if (n == 2 && b1 == 4'h0) begin
      n = 1;
    end else if (n == 2 && b0 == 4'h0) begin
      bt.addr = a[31:2] + 30'd1;
      bt.data = al[63:32];
      bt.be   = b1;
      bt.bc   = 2'd1;
      exp_q.push_back(bt);
      return 1;
    end
`endif
    bt.addr = a[31:2];
    bt.bc   = n[1:0];
    bt.data = al[31:0];
    bt.be   = b0;
    exp_q.push_back(bt);
    if (n == 2) begin
      bt.data = al[63:32];
      bt.be   = b1;
      exp_q.push_back(bt);
    end
    return n;
  endfunction

  // Monitor: scoreboard pop on accepted beats, Avalon hold rule, idle outputs.
  initial begin
    beat_t       bt;
    logic [68:0] cur, prev;
    logic        stalled, done_prev;
    stalled   = 1'b0;
    done_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      cur = {avm_write, avm_address, avm_writedata, avm_byteenable, avm_burstcount};
      if (rst) begin
        stalled   = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (stalled) check("stall_stable", 96'(cur), 96'(prev));
        stalled = avm_write && avm_waitrequest;
        prev    = cur;
        if (writeburst_done) begin
          done_cnt++;
          check("done_width", 96'(done_prev), 96'(0));
        end
        done_prev = writeburst_done;
        if (!avm_write) check("be_idle", 96'(avm_byteenable), 96'(0));
        if (avm_write && !avm_waitrequest) begin
          check("beat_expected", 96'(exp_q.size() != 0), 96'(1));
          if (exp_q.size() != 0) begin
            bt = exp_q.pop_front();
            check("avm_address", 96'(avm_address), 96'(bt.addr));
            check("avm_writedata", 96'(avm_writedata), 96'(bt.data));
            check("avm_byteenable", 96'(avm_byteenable), 96'(bt.be));
            check("avm_burstcount", 96'(avm_burstcount), 96'(bt.bc));
          end
        end
      end
    end
  end

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!writeburst_done && cyc < 100);
    check(tag, 96'(writeburst_done), 96'(1));
  endtask

  // Drives one request; keep=1 holds do through the IDLE cycle after HOLDOFF.
  task automatic run_burst(input string tag, input logic [31:0] a, input logic [1:0] len,
                           input logic [3:0] b0, input logic [3:0] b1, input logic [55:0] d,
                           input int stall, input bit keep);
    int n, cyc;
    n = push_exp(a, len, b0, b1, d);
    exp_done++;
    @(posedge clk); #1;
    writeburst_address      = a;
    writeburst_dword_length = len;
    writeburst_byteenable_0 = b0;
    writeburst_byteenable_1 = b1;
    writeburst_data         = d;
    writeburst_do           = 1'b1;
    wait_done({tag, "_done"}, cyc);
    check({tag, "_latency"}, 96'(cyc - 1), 96'(n + 1 + stall));
    @(posedge clk); #1;
    if (keep) begin
      @(posedge clk); #1;
    end
    writeburst_do = 1'b0;
  endtask

  initial begin
    int cyc, n;
    rst                     = 1'b1;
    writeburst_do           = 1'b0;
    writeburst_address      = '0;
    writeburst_dword_length = '0;
    writeburst_byteenable_0 = '0;
    writeburst_byteenable_1 = '0;
    writeburst_data         = '0;
    avm_waitrequest         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", 96'(avm_write), 96'(0));
    check("rst_address", 96'(avm_address), 96'(0));
    check("rst_writedata", 96'(avm_writedata), 96'(0));
    check("rst_burstcount", 96'(avm_burstcount), 96'(0));
    check("rst_done", 96'(writeburst_done), 96'(0));
    rst = 1'b0;

    run_burst("single", 32'h1000, 2'd1, 4'hF, 4'h0, 56'h00_0000_DDCC_BBAA, 0, 1'b0);
    run_burst("unaligned2", 32'h2003, 2'd2, 4'h8, 4'h7, 56'h0000_00_4433_2211, 0, 1'b0);
    run_burst("off1_two", 32'h3001, 2'd2, 4'hE, 4'hF, 56'h77_6655_4433_2211, 0, 1'b0);
    run_burst("len3_one", 32'h4002, 2'd3, 4'hC, 4'h3, 56'hA1_B2C3_D4E5_F607, 0, 1'b0);
    run_burst("len0_one", 32'hFFFF_FFFC, 2'd0, 4'h5, 4'hF, 56'h12_3456_789A_BCDE, 0, 1'b0);
    run_burst("trim_hi", 32'h5000, 2'd2, 4'hF, 4'h0, 56'h00_1111_2222_3333, 0, 1'b0);
    run_burst("trim_lo", 32'h6000, 2'd2, 4'h0, 4'hF, 56'h00_9999_8888_7777, 0, 1'b0);

    // Stall three cycles in beat 0 and two in beat 1.
    fork
      run_burst("stall", 32'h7000, 2'd2, 4'hF, 4'hF, 56'h00_CAFE_BABE_DEAD, 5, 1'b0);
      begin
        @(posedge clk); #1 avm_waitrequest = 1'b1;
        repeat (4) @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        @(posedge clk); #1 avm_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        #1 avm_waitrequest = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("stall_q_empty", 96'(exp_q.size()), 96'(0));

    // do held through HOLDOFF only: no second burst.
    run_burst("hold1", 32'h8000, 2'd1, 4'hF, 4'h0, 56'h00_0000_0102_0304, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("hold1_no_repeat", 96'(done_cnt), 96'(exp_done));
    // do held one more cycle into IDLE: exactly one repeat burst.
    n = push_exp(32'h9000, 2'd1, 4'hF, 4'h0, 56'h00_0000_0506_0708);
    exp_done++;
    run_burst("hold2", 32'h9000, 2'd1, 4'hF, 4'h0, 56'h00_0000_0506_0708, 0, 1'b1);
    wait_done("hold2_second_done", cyc);
    check("hold2_second_latency", 96'(cyc), 96'(n + 1));
    repeat (4) @(negedge clk);
    check("hold2_q_empty", 96'(exp_q.size()), 96'(0));
    check("hold2_done_count", 96'(done_cnt), 96'(exp_done));

    // Reset during a stalled beat 1: beat 0 is the only beat ever accepted.
    n = push_exp(32'hA000, 2'd2, 4'hF, 4'hF, 56'h00_5555_6666_7777);
    if (n == 2) void'(exp_q.pop_back());
    @(posedge clk); #1;
    writeburst_address      = 32'hA000;
    writeburst_dword_length = 2'd2;
    writeburst_byteenable_0 = 4'hF;
    writeburst_byteenable_1 = 4'hF;
    writeburst_data         = 56'h00_5555_6666_7777;
    writeburst_do           = 1'b1;
    repeat (2) @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    check("b1_write_before_rst", 96'(avm_write), 96'(1));
    check("b1_be_before_rst", 96'(avm_byteenable), 96'(4'hF));
    rst = 1'b1;
    #1;
    check("midrst_write", 96'(avm_write), 96'(0));
    check("midrst_address", 96'(avm_address), 96'(0));
    check("midrst_writedata", 96'(avm_writedata), 96'(0));
    check("midrst_byteenable", 96'(avm_byteenable), 96'(0));
    check("midrst_burstcount", 96'(avm_burstcount), 96'(0));
    check("midrst_done", 96'(writeburst_done), 96'(0));
    writeburst_do   = 1'b0;
    avm_waitrequest = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 96'(done_cnt), 96'(exp_done));
    run_burst("after_rst", 32'hB004, 2'd1, 4'h3, 4'h0, 56'h00_0000_0000_BEEF, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("final_q_empty", 96'(exp_q.size()), 96'(0));
    check("final_done_count", 96'(done_cnt), 96'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
